// File: rtl/morra_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morra_scoreboard: round/game tallies and finished-game FIFO for Morra.    |
// | Option: MORRA_SCOREBOARD_STREAK_EN adds win-streak tracking outputs.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module morra_scoreboard #(
  parameter int CNT_W      = 8,
  parameter int ROUND_W    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inizia_i,
  input  logic [1:0]             manche_i,
  input  logic [1:0]             partita_i,
  input  logic                   clear_i,
  output logic                   game_active_o,
  output logic [ROUND_W-1:0]     cur_p1_o,
  output logic [ROUND_W-1:0]     cur_p2_o,
  output logic [ROUND_W-1:0]     cur_played_o,
  output logic [CNT_W-1:0]       p1_games_o,
  output logic [CNT_W-1:0]       p2_games_o,
  output logic [CNT_W-1:0]       draw_games_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [2+2*ROUND_W-1:0] res_data_o,
  output logic                   res_dropped_o
`ifdef MORRA_SCOREBOARD_STREAK_EN
  ,
  output logic [CNT_W-1:0]       streak_cur_o,
  output logic [CNT_W-1:0]       streak_best_o,
  output logic [1:0]             streak_who_o
`endif
);

  localparam int REC_W = 2 + 2*ROUND_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_IN_GAME   = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  function automatic logic [ROUND_W-1:0] inc_r(input logic [ROUND_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             state_q;
  logic               game_active_q;
  logic [ROUND_W-1:0] cur_p1_q, cur_p2_q, cur_played_q;
  logic [ROUND_W-1:0] cur_p1_d, cur_p2_d, cur_played_d;
  logic               game_end;

  always_comb begin
    cur_p1_d     = cur_p1_q;
    cur_p2_d     = cur_p2_q;
    cur_played_d = cur_played_q;
    game_end     = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (inizia_i) begin
          cur_p1_d     = '0;
          cur_p2_d     = '0;
          cur_played_d = '0;
        end
      end
      S_IN_GAME: begin
        if (inizia_i) begin
          cur_p1_d     = '0;
          cur_p2_d     = '0;
          cur_played_d = '0;
        end else begin
          // The final round is folded in before the game result is logged.
          if (manche_i != 2'b00) cur_played_d = inc_r(cur_played_q);
          if (manche_i == 2'b01) cur_p1_d = inc_r(cur_p1_q);
          if (manche_i == 2'b10) cur_p2_d = inc_r(cur_p2_q);
          game_end = (partita_i != 2'b00);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      game_active_q <= 1'b0;
      cur_p1_q      <= '0;
      cur_p2_q      <= '0;
      cur_played_q  <= '0;
    end else begin
      cur_p1_q     <= cur_p1_d;
      cur_p2_q     <= cur_p2_d;
      cur_played_q <= cur_played_d;
      case (state_q)
        S_IDLE, S_GAME_OVER: begin
          if (inizia_i) begin
            state_q       <= S_IN_GAME;
            game_active_q <= 1'b1;
          end
        end
        S_IN_GAME: begin
          if (game_end) begin
            state_q       <= S_GAME_OVER;
            game_active_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          game_active_q <= 1'b0;
        end
      endcase
    end
  end

  logic [CNT_W-1:0] p1_games_q, p2_games_q, draw_games_q;
  logic             session_upd;

  assign session_upd = game_end && !clear_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_games_q   <= '0;
      p2_games_q   <= '0;
      draw_games_q <= '0;
    end else if (clear_i) begin
      p1_games_q   <= '0;
      p2_games_q   <= '0;
      draw_games_q <= '0;
    end else if (session_upd) begin
      if (partita_i == 2'b01) p1_games_q   <= inc_c(p1_games_q);
      if (partita_i == 2'b10) p2_games_q   <= inc_c(p2_games_q);
      if (partita_i == 2'b11) draw_games_q <= inc_c(draw_games_q);
    end
  end

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             dropped_q;
  logic             fifo_full, fifo_pop, fifo_push, fifo_drop;

  assign fifo_full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_pop  = (count_q != '0) && res_ready_i;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign fifo_push = session_upd && (!fifo_full || fifo_pop);
  assign fifo_drop = session_upd && fifo_full && !fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else if (clear_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (fifo_push) begin
        mem_q[wr_ptr_q] <= {partita_i, cur_p1_d, cur_p2_d};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (fifo_drop) dropped_q <= 1'b1;
    end
  end

`ifdef MORRA_SCOREBOARD_STREAK_EN
  logic [CNT_W-1:0] streak_cur_q, streak_best_q, streak_cur_d;
  logic [1:0]       streak_who_q, last_win_q, last_win_d;

  always_comb begin
    streak_cur_d = streak_cur_q;
    last_win_d   = last_win_q;
    if (partita_i == 2'b11) begin
      streak_cur_d = '0;
      last_win_d   = 2'b00;
    end else if (partita_i == last_win_q) begin
      streak_cur_d = inc_c(streak_cur_q);
    end else begin
      streak_cur_d = CNT_W'(1);
      last_win_d   = partita_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_cur_q  <= '0;
      streak_best_q <= '0;
      streak_who_q  <= 2'b00;
      last_win_q    <= 2'b00;
    end else if (clear_i) begin
      streak_cur_q  <= '0;
      streak_best_q <= '0;
      streak_who_q  <= 2'b00;
      last_win_q    <= 2'b00;
    end else if (session_upd) begin
      streak_cur_q <= streak_cur_d;
      last_win_q   <= last_win_d;
      if (streak_cur_d > streak_best_q) begin
        streak_best_q <= streak_cur_d;
        streak_who_q  <= partita_i;
      end
    end
  end

  assign streak_cur_o  = streak_cur_q;
  assign streak_best_o = streak_best_q;
  assign streak_who_o  = streak_who_q;
`endif

  assign game_active_o = game_active_q;
  assign cur_p1_o      = cur_p1_q;
  assign cur_p2_o      = cur_p2_q;
  assign cur_played_o  = cur_played_q;
  assign p1_games_o    = p1_games_q;
  assign p2_games_o    = p2_games_q;
  assign draw_games_o  = draw_games_q;
  assign res_valid_o   = (count_q != '0);
  assign res_data_o    = mem_q[rd_ptr_q];
  assign res_dropped_o = dropped_q;

endmodule
`default_nettype wire
